lsu_mem_initiator: RTL

- CPU-side load/store initiator: the requesting end of the data-memory stall protocol.
- Accepts one load/store per handshake from the execute stage and computes the effective address.
- Encodes size/sign into sign_mask and lane-replicates store data.
- Drives a single-cycle request, tracks the memory's stall pulse, captures read data and returns one response to the pipeline.

---
 rtl/lsu_mem_initiator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: issues one load/store at a time over the stalling data-memory handshake
module lsu_mem_initiator #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_base_i,
  input  logic [ADDR_W-1:0] req_offset_i,
  input  logic [ADDR_W-1:0] req_wdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [ADDR_W-1:0] mem_wdata_o,
  output logic              mem_w_ena_o,
  output logic              mem_r_ena_o,
  output logic [3:0]        mem_sign_mask_o,
  input  logic [ADDR_W-1:0] mem_rdata_i,
  input  logic              mem_stall_i,
  output logic              resp_valid_o,
  output logic [ADDR_W-1:0] resp_rdata_o,
  output logic              resp_misalign_o,
  output logic              resp_err_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ea;
  logic [3:0] mask_q, mask_d;
  logic [7:0] cnt_q, cnt_d;
  logic store_q, store_d, seen_q, seen_d, misalign_q, misalign_d, err_q, err_d;
  logic is_byte, is_half, misaligned;
  always_comb begin
    ea = req_base_i + req_offset_i;
    is_byte = req_funct3_i == 3'b000 || (!req_store_i && req_funct3_i == 3'b100);
    is_half = req_funct3_i == 3'b001 || (!req_store_i && req_funct3_i == 3'b101);
    misaligned = is_half ? ea[0] : (!is_byte && |ea[1:0]);
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    store_d = store_q;
    seen_d = seen_q;
    misalign_d = misalign_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: begin
        rdata_d = '0;
        misalign_d = 1'b0;
        err_d = 1'b0;
        if (req_valid_i) begin
          addr_d = ea;
          store_d = req_store_i;
          mask_d = {1'b0, !req_store_i && !req_funct3_i[2] && (is_byte || is_half), is_byte, is_half};
          wdata_d = !req_store_i ? '0 : is_byte ? {4{req_wdata_i[7:0]}} :
                    is_half ? {2{req_wdata_i[15:0]}} : req_wdata_i;
          seen_d = 1'b0;
          cnt_d = '0;
          misalign_d = misaligned;
          state_d = misaligned ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        seen_d = seen_q | mem_stall_i;
        if (seen_q && !mem_stall_i) begin
          rdata_d = store_q ? '0 : mem_rdata_i;
          state_d = S_RESP;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          err_d = 1'b1;
          state_d = S_RESP;
        end else
          cnt_d = cnt_q + 8'd1;
      end
      default: begin
        rdata_d = '0;
        misalign_d = 1'b0;
        err_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      store_q <= 1'b0;
      seen_q <= 1'b0;
      misalign_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      store_q <= store_d;
      seen_q <= seen_d;
      misalign_q <= misalign_d;
      err_q <= err_d;
    end
  end
  assign req_ready_o = state_q == S_IDLE;
  assign resp_valid_o = state_q == S_RESP;
  assign mem_w_ena_o = state_q == S_ISSUE && store_q;
  assign mem_r_ena_o = state_q == S_ISSUE && !store_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_sign_mask_o = mask_q;
  assign resp_rdata_o = rdata_q;
  assign resp_misalign_o = misalign_q;
  assign resp_err_o = err_q;
endmodule
